// File: rtl/hb_loader_pkg.sv
// Shared types and constants for the serial boot loader and its byte receiver.
package hb_loader_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam logic [7:0]  LEN_HI_MASK          = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises rx, re-checks the start bit at mid-bit and
// samples data and stop bits at bit-period intervals from there.
module uart_rx_byte
  import hb_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_prev  <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      sync_prev  <= sync2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!en) begin
        rx_state <= RX_IDLE;
        cnt      <= '0;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            if (sync_prev && !sync2) begin
              rx_state <= RX_START;
              cnt      <= '0;
            end
          end
          RX_START: begin
            if (cnt == HALF_LAST) begin
              cnt      <= '0;
              bit_idx  <= '0;
              // A start bit that has gone high again by mid-bit was a glitch.
              rx_state <= sync2 ? RX_IDLE : RX_BITS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RX_BITS: begin
            if (cnt == FULL_LAST) begin
              cnt   <= '0;
              shreg <= {sync2, shreg[7:1]};
              if (bit_idx == 3'd7) rx_state <= RX_STOP;
              else                 bit_idx  <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (cnt == FULL_LAST) begin
              cnt      <= '0;
              rx_state <= RX_IDLE;
              if (sync2) begin
                byte_o     <= shreg;
                byte_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/serial_boot_loader.sv
// Boot loader: receives LEN_HI, LEN_LO, N data bytes and a CSUM byte over 8N1,
// writes the data to RAM from address 0 and releases the CPU on a good checksum.
module serial_boot_loader
  import hb_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_rst_bar,
  output logic              done,
  output logic              error
);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              frame_err;
  logic              rx_en;
  state_t            state;
  logic [11:0]       len;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        sum;

  assign rx_en = (state != DONE) && (state != ERROR);

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .en        (rx_en),
    .rx        (rx),
    .byte_o    (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      idx         <= '0;
      sum         <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      cpu_rst_bar <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (frame_err && rx_en) begin
        state <= ERROR;
        error <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          IDLE: begin
            if ((rx_byte & LEN_HI_MASK) != '0) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              len[11:8] <= rx_byte[3:0];
              state     <= LEN_LO;
            end
          end
          LEN_LO: begin
            len[7:0] <= rx_byte;
            idx      <= '0;
            sum      <= '0;
            state    <= ({len[11:8], rx_byte} == 12'd0) ? CSUM : DATA;
          end
          DATA: begin
            mem_we   <= 1'b1;
            mem_addr <= idx;
            mem_data <= rx_byte;
            sum      <= sum + rx_byte;
            if (12'(idx) == len - 12'd1) state <= CSUM;
            else                         idx   <= idx + 1'b1;
          end
          CSUM: begin
            if (rx_byte == sum) begin
              state       <= DONE;
              done        <= 1'b1;
              cpu_rst_bar <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/serial_boot_loader.md
# serial_boot_loader

Loads a program image into the Hummingbird program/data RAM over an asynchronous 8N1 serial line before the CPU runs. The block holds the CPU in reset and writes each received byte to sequential RAM addresses starting at 0. It verifies a trailing checksum and releases the CPU only after a good image. It sits directly upstream of the CPU core and drives the RAM write port and the core's active-low reset during boot.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 4 and even.
- ADDR_W, 12: RAM address width, matching the CPU's 12-bit address space.
- clk  in  1: system clock, rising edge.
- rst  in  1: reset; synchronous, active-high.
- rx  in  1: serial input; idles high, asynchronous to clk.
- mem_addr  out  ADDR_W: RAM write address.
- mem_data  out  8: RAM write data.
- mem_we  out  1: one-cycle write strobe, active-high.
- cpu_rst_bar  out  1: CPU reset, active-low; low until the image is accepted.
- done  out  1: image accepted; sticky.
- error  out  1: framing, length or checksum failure; sticky.

## Operation
- **Frame format:** LEN_HI, LEN_LO, N data bytes, CSUM.
  - N = {LEN_HI[3:0], LEN_LO}, giving 0..4095.
  - LEN_HI[7:4] must be 0.
  - CSUM = (sum of the N data bytes) mod 256.
- **Byte reception:** handled by the sub-module.
  - 2-flop synchroniser on rx.
  - A start edge is a high-to-low transition seen on the synchronised rx.
  - The start bit is re-sampled at CLKS_PER_BIT/2; if high there, it is a glitch and the receiver returns to idle.
  - Data bits are sampled at CLKS_PER_BIT intervals from mid-start, LSB first.
  - Stop bit is sampled in the same way. Stop = 0 raises a framing error instead of a byte.
  - Each received byte produces a one-cycle byte_valid pulse.
- **FSM states:** IDLE, LEN_LO, DATA, CSUM, DONE, ERROR.
  - IDLE: first byte is LEN_HI. If its upper nibble is nonzero, go to ERROR. Otherwise latch the length nibble and go to LEN_LO.
  - LEN_LO: latch the byte. If N = 0, go to CSUM; otherwise go to DATA with index = 0 and sum = 0.
  - DATA: per byte, write mem_data = byte and mem_addr = index, then add the byte to the 8-bit sum. Go to CSUM when index = N-1; otherwise increment index.
  - CSUM: if the byte equals the sum, go to DONE; otherwise go to ERROR.
  - DONE: done = 1 and cpu_rst_bar = 1. All further rx traffic is ignored and the receiver stays disabled.
  - ERROR: error = 1 and cpu_rst_bar stays 0. All further rx traffic is ignored until rst.
- **Framing error:** a framing error in any state before DONE goes to ERROR.
- **Arithmetic:**
  - index is ADDR_W bits and never wraps, because N ≤ 4095.
  - sum wraps mod 256.

## Timing
- **Reset values** (next edge with rst = 1): mem_addr = 0, mem_data = 0, mem_we = 0, cpu_rst_bar = 0, done = 0, error = 0, FSM in IDLE, receiver idle.
- **Reset mid-operation:** rst in any state, including mid-byte, aborts the frame. There is no partial write and no strobe in the reset cycle. The loader then waits for a new LEN_HI.
- **byte_valid:** asserted 1 cycle after the stop-bit sample cycle.
- **mem_we:** asserted in the cycle after byte_valid, for exactly 1 cycle. mem_addr and mem_data are stable during that cycle and hold their values afterwards.
- **Release:** done and cpu_rst_bar change together, 1 cycle after the CSUM byte_valid.
- **Error:** error is set 1 cycle after the offending byte_valid or framing detection.
- **Back-to-back bytes:** one stop bit followed immediately by the next start must be received without loss. Byte spacing is ≥ 10·CLKS_PER_BIT, so writes never overlap.
- **rx during reset:** ignored. The synchroniser flops reset to 1.

## Structure
- **Shared package hb_loader_pkg:**
  - state enum: IDLE, LEN_LO, DATA, CSUM, DONE, ERROR.
  - LEN_HI_MASK = 8'hF0.
  - Default CLKS_PER_BIT.
- **Sub-module uart_rx_byte:**
  - Contains the synchroniser, the bit counter, the baud counter and the sample logic.
  - Ports: clk, rst, en, rx, byte_o[7:0], byte_valid, frame_err.
  - The top-level FSM, index, length and sum registers live in serial_boot_loader.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- **Reset:** hold rst for 3 cycles with rx = 1 -> all outputs 0, cpu_rst_bar = 0. No mem_we for 1000 cycles.
- **Good image:** send 00 03 A5 5A 01 00 -> writes (0,A5), (1,5A), (2,01), each mem_we one cycle wide, then done = 1 and cpu_rst_bar = 1, error = 0.
- **Empty image:** send 00 00 00 -> no mem_we, done = 1. Then send 00 00 00 again -> ignored, no change.
- **Bad checksum:** send 00 02 10 20 31 -> two writes, then error = 1, cpu_rst_bar = 0, done = 0.
- **Errors without a good frame:**
  - LEN_HI = 10 -> error on the first byte, no writes.
  - Stop bit forced 0 on the second data byte -> error, only one write.
  - A 4-cycle low glitch on idle rx -> no byte_valid.
- **Reset mid-frame:** assert rst at bit 4 of data byte 2 of a 5-byte image, then resend the full image 00 05 01 02 03 04 05 0F -> 5 writes to addresses 0..4, done = 1.
